wb_arb8: RTL and testbench
==========================

# wb_arb8

Round-robin arbiter that shares one 8:1 datapath mux (and the single resource behind it, e.g. the shared write-back/memory port) among eight requesters. It owns the mux select: it chooses one requester, drives a one-hot grant and the 3-bit select, and holds the choice for a multi-cycle transaction. A hold limit provides fairness. It sits beside the 8:1 mux in the pipelined datapath, and its `sel` drives the mux `S` input directly.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles one owner keeps the grant while others wait; legal range 1..15.
- `CNT_W`, default 4: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `req`  in  8: level requests; bit i = requester i. Held high for the whole transaction.
- `gnt`  out  8: registered one-hot grant, or all zeros.
- `sel`  out  3: registered binary index of the owner; drives mux `S`.
- `valid`  out  1: registered; high when `gnt` is non-zero.

## Operation
- States: IDLE and GRANT. The encoding is given under Structure.
- Pointer `ptr[2:0]`: the requester with highest priority in the next pick. The search order is ptr, ptr+1, …, ptr+7, modulo 8 (wrap-around).
- **IDLE.**
  - If `req` is non-zero, pick the first set bit in search order.
  - Next: GRANT, `gnt` = onehot(pick), `sel` = pick, `cnt` = 0, `ptr` = pick+1 (mod 8).
  - If `req` is zero, stay in IDLE with outputs zero.
- **GRANT (owner o = `sel`).**
  - Owner release (`req[o]` = 0): pick from `req` with o masked out. If a pick exists, hand over directly (no idle bubble) with the same updates as from IDLE. Otherwise go to IDLE, clear outputs and keep `ptr`.
  - Owner still requesting, others waiting, `cnt` = MAX_HOLD-1: forced rotation. Pick from `req` with o masked and hand over.
  - Owner still requesting, others waiting, `cnt` < MAX_HOLD-1: keep the grant and increment `cnt`.
  - Owner still requesting, no other requests: keep the grant and hold `cnt` at 0. The owner is never cut off when nobody else waits.
- `cnt` never exceeds MAX_HOLD-1, so there is no overflow.
- `gnt` is always one-hot or zero, and `sel` equals its index whenever `valid` = 1. While `valid` = 0, `sel` = 0.
- Changes on non-owner `req` lines during GRANT affect only the rotation decision, never the current owner.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state = IDLE, `gnt` = 0, `sel` = 0, `valid` = 0, `ptr` = 0, `cnt` = 0.
- Reset asserted mid-transaction clears everything immediately, with no wait for a clock edge.
- Grant latency: `req` sampled high at edge N (state IDLE) gives `gnt`/`valid`/`sel` at edge N and visible for cycle N+1. One cycle of request-to-grant delay.
- Handover latency: owner drops `req` in cycle N; the new owner's grant is visible in cycle N+1. Zero bubble cycles.
- Maximum continuous tenure under contention: MAX_HOLD cycles.
- Worst-case wait for any held request: 7 × MAX_HOLD cycles.
- Simultaneous release by the owner and a new request from the same index: the mask excludes the owner for that pick. The index can win again only on a later pick.
- All outputs come directly from flops; there is no combinational path from `req` to an output.

## Structure
- Shared header `arb_defs.vh`:
  - state localparams `ARB_IDLE` = 1'b0 and `ARB_GRANT` = 1'b1;
  - `ARB_N` = 8;
  - `ARB_IW` = 3.
- Sub-module `rr_pick8`: combinational.
  - Inputs: `req[7:0]`, `mask[7:0]`, `ptr[2:0]`.
  - Outputs: `idx[2:0]`, `found`.
  - Implements rotate, priority-encode, rotate back.
- The top level instantiates one `rr_pick8`. It contains the state flop, `ptr`, `cnt` and the output registers.

## Test plan
- Reset: pulse `rst_n` = 0 mid-grant with `req` = 8'hFF. Outputs go to 0 asynchronously. After release, the first grant goes to index 0 (`gnt` = 8'h01, `sel` = 0).
- Single requester: `req` = 8'h20 for 10 cycles. `gnt` = 8'h20 and `sel` = 5 from the cycle after `req` rises. The grant persists for all 10 cycles with no forced release. Outputs return to 0 one cycle after `req` drops.
- Rotation and wrap-around: `req` = 8'h81 with MAX_HOLD = 4.
  - Grant order is 0, 7, 0, 7, …
  - Each tenure lasts exactly 4 cycles.
  - `sel` alternates 0/7 with no cycle of `valid` = 0.
- Early release handover: owner 2 drops `req` after 2 cycles while `req[3]` and `req[6]` are high. `gnt` = 8'h08 the next cycle, with no bubble.
- Fairness: `req` = 8'hFF held. Over 32 cycles (MAX_HOLD = 4), every index is granted exactly once, in order 0..7.
- Invariant checks on every cycle:
  - `gnt` is one-hot or zero;
  - `sel` equals the index of `gnt` whenever `valid` = 1;
  - `cnt` ≤ MAX_HOLD-1;
  - `valid` equals the OR of `gnt`.

Source files
------------

// File: rtl/wb_arb8_pkg.sv
// Shared definitions for the 8-way round-robin write-back arbiter.
package wb_arb8_pkg;
  localparam int ARB_N  = 8;
  localparam int ARB_IW = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;
endpackage

// File: rtl/wb_arb8_rr_pick8.sv
// Combinational round-robin pick: first set bit of (req & ~mask) searching ptr, ptr+1, ... mod 8.
module rr_pick8
  import wb_arb8_pkg::*;
(
  input  logic [ARB_N-1:0]  req,
  input  logic [ARB_N-1:0]  mask,
  input  logic [ARB_IW-1:0] ptr,
  output logic [ARB_IW-1:0] idx,
  output logic              found
);
  logic [ARB_N-1:0]   m;
  logic [2*ARB_N-1:0] dbl;
  logic [ARB_N-1:0]   rot;
  logic [ARB_IW-1:0]  off;

  assign m   = req & ~mask;
  assign dbl = {m, m};
  // rot[i] is requester (ptr+i) mod 8, so bit 0 has highest priority
  assign rot = dbl[ptr +: ARB_N];

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = ARB_N-1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = ARB_IW'(i);
      end
    end
  end

  assign idx = ptr + off;
endmodule

// File: rtl/wb_arb8.sv
// Round-robin owner of the shared 8:1 write-back mux select, with a hold limit for fairness.
module wb_arb8
  import wb_arb8_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ARB_N-1:0]  req,
  output logic [ARB_N-1:0]  gnt,
  output logic [ARB_IW-1:0] sel,
  output logic              valid
);
  arb_state_e        state, state_nxt;
  logic [ARB_IW-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ARB_N-1:0]  gnt_nxt;
  logic [ARB_IW-1:0] sel_nxt;
  logic              valid_nxt;

  logic [ARB_N-1:0]  mask;
  logic [ARB_IW-1:0] pick;
  logic              found;
  logic              own_req;

  // In GRANT the owner is excluded, so found also means "someone else is waiting"
  assign mask    = (state == ARB_GRANT) ? (ARB_N'(1) << sel) : '0;
  assign own_req = req[sel];

  rr_pick8 u_pick (
    .req   (req),
    .mask  (mask),
    .ptr   (ptr),
    .idx   (pick),
    .found (found)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    valid_nxt = valid;
    case (state)
      ARB_IDLE: begin
        if (found) begin
          state_nxt = ARB_GRANT;
          gnt_nxt   = ARB_N'(1) << pick;
          sel_nxt   = pick;
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
          ptr_nxt   = pick + 1'b1;
        end
      end
      ARB_GRANT: begin
        if (found && (!own_req || cnt == CNT_W'(MAX_HOLD-1))) begin
          gnt_nxt   = ARB_N'(1) << pick;
          sel_nxt   = pick;
          cnt_nxt   = '0;
          ptr_nxt   = pick + 1'b1;
        end else if (!own_req) begin
          state_nxt = ARB_IDLE;
          gnt_nxt   = '0;
          sel_nxt   = '0;
          valid_nxt = 1'b0;
          cnt_nxt   = '0;
        end else if (found) begin
          cnt_nxt   = cnt + 1'b1;
        end else begin
          // sole requester is never cut off
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        gnt_nxt   = '0;
        sel_nxt   = '0;
        valid_nxt = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      ptr   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      sel   <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
      valid <= valid_nxt;
    end
  end
endmodule

// File: tb/tb_wb_arb8.sv
// Directed + random bench for wb_arb8 against a search-order reference model.
module tb_wb_arb8;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;

  int checks = 0;
  int failures = 0;

  // reference model: owner index (-1 = none), next-priority pointer, cycles held so far
  int m_own = -1;
  int m_ptr = 0;
  int m_ten = 0;

  wb_arb8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int excl, input int p);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (p + k) % 8;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [7:0] r);
    int n;
    if (m_own < 0) begin
      n = pick(r, -1, m_ptr);
      if (n >= 0) begin m_own = n; m_ptr = (n + 1) % 8; m_ten = 1; end
    end else if (!r[m_own]) begin
      n = pick(r, m_own, m_ptr);
      if (n >= 0) begin m_own = n; m_ptr = (n + 1) % 8; m_ten = 1; end
      else m_own = -1;
    end else begin
      n = pick(r, m_own, m_ptr);
      if (n < 0) m_ten = 1;
      else if (m_ten == MAX_HOLD) begin m_own = n; m_ptr = (n + 1) % 8; m_ten = 1; end
      else m_ten++;
    end
  endtask

  task automatic check_model();
    logic [7:0] eg;
    eg = (m_own >= 0) ? (8'd1 << m_own) : 8'd0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("sel", 32'(sel), (m_own >= 0) ? 32'(m_own) : 32'd0);
    chk("valid", 32'(valid), 32'(m_own >= 0));
    chk("onehot0", 32'((gnt & (gnt - 8'd1)) == 8'd0), 32'd1);
    chk("valid_or", 32'(valid), 32'(|gnt));
    chk("cnt_bound", 32'(dut.cnt <= 4'(MAX_HOLD-1)), 32'd1);
  endtask

  // req applied at negedge, clocked at posedge, outputs checked at next negedge
  task automatic cyc(input logic [7:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    req = '0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_own = -1; m_ptr = 0; m_ten = 0;
  endtask

  int per_idx [8];

  initial begin
    @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_sel", 32'(sel), 32'd0);
    rst_n = 1'b1;

    // async reset mid-grant
    for (int k = 0; k < 6; k++) cyc(8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_valid", 32'(valid), 32'd0);
    chk("async_rst_sel", 32'(sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_own = -1; m_ptr = 0; m_ten = 0;
    cyc(8'hFF);
    chk("post_rst_gnt", 32'(gnt), 32'h01);
    chk("post_rst_sel", 32'(sel), 32'd0);

    // single requester never cut off
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc(8'h20);
      chk("single_gnt", 32'(gnt), 32'h20);
      chk("single_sel", 32'(sel), 32'd5);
    end
    cyc(8'h00);
    chk("single_drop", 32'(gnt), 32'd0);

    // rotation with wrap: 0,7,0,7 each for MAX_HOLD cycles
    do_reset();
    for (int k = 0; k < 16; k++) begin
      cyc(8'h81);
      chk("rot_sel", 32'(sel), ((k / MAX_HOLD) % 2 == 1) ? 32'd7 : 32'd0);
      chk("rot_valid", 32'(valid), 32'd1);
    end

    // early release hands over without a bubble
    do_reset();
    cyc(8'h4C);
    cyc(8'h4C);
    chk("early_owner", 32'(gnt), 32'h04);
    cyc(8'h48);
    chk("early_handover", 32'(gnt), 32'h08);

    // fairness: every index held exactly MAX_HOLD cycles over 32 cycles
    do_reset();
    for (int i = 0; i < 8; i++) per_idx[i] = 0;
    for (int k = 0; k < 32; k++) begin
      cyc(8'hFF);
      chk("fair_order", 32'(sel), 32'(k / MAX_HOLD));
      if (valid) per_idx[sel]++;
    end
    for (int i = 0; i < 8; i++) chk("fair_count", 32'(per_idx[i]), 32'(MAX_HOLD));

    // random traffic: mostly hold the current vector, sometimes flip bits
    do_reset();
    begin
      logic [7:0] r;
      r = '0;
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, 3) == 0) r = 8'($urandom);
        else if ($urandom_range(0, 3) == 0) r = r ^ (8'd1 << $urandom_range(0, 7));
        cyc(r);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
